dcache_tag_ctrl: RTL and testbench
==================================

# dcache_tag_ctrl

Controller in front of the 16-entry × 25-bit data-cache tag SRAM macro. It serialises tag lookups and tag updates onto the macro's single RW port, and compares the read-back tag to produce a registered hit/miss/dirty response. After reset, or on request, it sweeps all 16 entries invalid, because the macro has no reset. It sits between the dcache request pipeline / miss handler and the tag SRAM.

## Interface
Parameters:
- OFFSET_WIDTH, 5, line offset bits (32-byte lines)
- INDEX_WIDTH, 4, set index bits; must match the SRAM address width
- TAG_WIDTH, 23, address tag bits (32 − INDEX_WIDTH − OFFSET_WIDTH)
- WORD_WIDTH, 25, SRAM word width: bit 24 valid, bit 23 dirty, bits 22:0 tag

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, shared with the SRAM clk0
- rst_n  in  1  asynchronous active-low reset
- req_valid / req_ready  in/out  1/1  lookup handshake
- req_addr  in  32  lookup byte address
- upd_valid / upd_ready  in/out  1/1  tag-write handshake
- upd_index  in  INDEX_WIDTH  entry to write
- upd_tag  in  TAG_WIDTH  tag to store
- upd_v, upd_d  in  1/1  valid and dirty bits to store
- inv_all  in  1  single-cycle pulse: invalidate all entries
- init_done  out  1  high when the array is usable
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_hit, rsp_dirty  out  1/1  stored valid AND tag match; stored dirty bit
- rsp_tag  out  TAG_WIDTH  stored tag, used for victim writeback
- rsp_index  out  INDEX_WIDTH  index of the lookup
- tag_csb0, tag_web0  out  1/1  SRAM chip select and write enable, both active-low
- tag_addr0  out  INDEX_WIDTH  SRAM address
- tag_din0  out  WORD_WIDTH  SRAM write data
- tag_dout0  in  WORD_WIDTH  SRAM read data, valid the cycle after the read is issued

## Operation
- FSM states:
  - RST: entered asynchronously on reset.
  - INIT: sweep in progress.
  - RUN: normal operation.
- FSM transitions:
  - RST → INIT on the first clk edge after reset deasserts.
  - INIT → RUN after the write to index 15.
  - RUN → INIT when inv_all is sampled high.
- INIT: one SRAM write per cycle, index 0..15, data all-zero. tag_csb0=0, tag_web0=0.
- RUN arbitration: update has priority over lookup.
  - upd_ready = (state==RUN) && !inv_all.
  - req_ready = upd_ready && !upd_valid.
- Lookup accept: drive tag_csb0=0, tag_web0=1, tag_addr0=req_addr[8:5]. Register the request tag req_addr[31:9] and the index into stage 1.
- Stage 1 (cycle after accept):
  - rsp_hit = tag_dout0[24] && (tag_dout0[22:0] == stage-1 tag).
  - rsp_dirty = tag_dout0[23]; rsp_tag = tag_dout0[22:0].
  - All of these are registered into the response outputs.
- Update accept: tag_csb0=0, tag_web0=0, tag_addr0=upd_index, tag_din0={upd_v, upd_d, upd_tag}.
- Idle cycles: tag_csb0=1. SRAM outputs are combinational from state and handshakes; tag_din0 and tag_addr0 are don't-care when tag_csb0=1.
- inv_all in RUN:
  - Blocks a new accept that cycle.
  - A lookup already in flight still produces its response.
  - Sweep restarts at index 0.
- No bypass is needed. A write accepted in cycle N lands in the SRAM at the end of N+1. A read accepted in N+1 or later observes the new value, and the bench must check this.

## Timing
- Reset values: state=RST, sweep counter=0, init_done=0, req_ready=0, upd_ready=0, rsp_*=0, tag_csb0=1, tag_web0=1, tag_addr0=0, tag_din0=0.
- Sweep: cycles 1..16 after reset release write indices 0..15. init_done goes high in cycle 17.
- Lookup latency: accept in cycle N → rsp_valid in cycle N+2.
- Throughput: one lookup per cycle; back-to-back responses are allowed.
- Update latency: accept in N → array updated at the end of N+1. No response is generated.
- Reset mid-operation (any state):
  - All outputs return to reset values immediately.
  - The in-flight response is dropped.
  - The full sweep reruns; partial SRAM writes are overwritten.

## Structure
- Shared package dcache_pkg holds:
  - The width constants: OFFSET_WIDTH, INDEX_WIDTH, TAG_WIDTH, WORD_WIDTH.
  - The tag-word field positions: V_BIT=24, D_BIT=23, TAG_MSB=22.
  - The FSM state enum {RST, INIT, RUN}.
- No sub-module. The sweep counter, arbiter and comparator are inline. The SRAM macro is instantiated by the parent, not inside this block.

## Test plan
- Reset release: tag_addr0 steps 0..15 with tag_web0=0, tag_din0=0 in cycles 1..16. init_done=1 in cycle 17. Lookup of 0x0000_0000 → rsp_hit=0 two cycles after accept.
- Fill then hit: upd index 3, tag 0x12345, v=1, d=1 accepted in cycle N. Lookup of 0x0246_8A60 accepted in N+1 → rsp_valid in N+3 with rsp_hit=1, rsp_dirty=1, rsp_index=3.
- Back-to-back conflict: after the fill above, lookups of 0x0246_8A60 then 0x0246_8C60 on consecutive cycles. Responses arrive on consecutive cycles: hit, then miss with rsp_tag=0x12345.
- Simultaneous upd_valid and req_valid: the update is accepted and req_ready=0 that cycle. The lookup is accepted next cycle and reflects the updated entry.
- inv_all after several fills: init_done drops for 16 cycles and the sweep covers indices 0..15. The lookup in flight when inv_all arrives still responds. Every subsequent lookup → rsp_hit=0.
- rst_n asserted in sweep cycle 8: all outputs go to reset values. After release, a full 16-write sweep occurs before init_done=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared widths, tag-word layout and FSM states for dcache_tag_ctrl
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int OFFSET_WIDTH = 5;
    localparam int INDEX_WIDTH  = 4;
    localparam int TAG_WIDTH    = 23;
    localparam int WORD_WIDTH   = 25;

    localparam int V_BIT   = 24;
    localparam int D_BIT   = 23;
    localparam int TAG_MSB = 22;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_tag_ctrl.sv
// ============================================================================
// dcache_tag_ctrl : serialises tag lookups/updates onto the single-port tag
//                   SRAM, sweeps it invalid after reset/inv_all, compares tags
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dcache_tag_ctrl #(
    parameter int OFFSET_WIDTH = dcache_pkg::OFFSET_WIDTH,
    parameter int INDEX_WIDTH  = dcache_pkg::INDEX_WIDTH,
    parameter int TAG_WIDTH    = dcache_pkg::TAG_WIDTH,
    parameter int WORD_WIDTH   = dcache_pkg::WORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic [TAG_WIDTH-1:0]   upd_tag,
    input  logic                   upd_v,
    input  logic                   upd_d,
    input  logic                   inv_all,
    output logic                   init_done,
    output logic                   rsp_valid,
    output logic                   rsp_hit,
    output logic                   rsp_dirty,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic [INDEX_WIDTH-1:0] rsp_index,
    output logic                   tag_csb0,
    output logic                   tag_web0,
    output logic [INDEX_WIDTH-1:0] tag_addr0,
    output logic [WORD_WIDTH-1:0]  tag_din0,
    input  logic [WORD_WIDTH-1:0]  tag_dout0
);

    import dcache_pkg::*;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;
    logic [INDEX_WIDTH-1:0] s1_index_q, s1_index_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic                   rsp_dirty_q, rsp_dirty_d;
    logic [TAG_WIDTH-1:0]   rsp_tag_q, rsp_tag_d;
    logic [INDEX_WIDTH-1:0] rsp_index_q, rsp_index_d;

    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic                   unused_offset;

    assign req_tag       = req_addr[31 -: TAG_WIDTH];
    assign req_index     = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        s1_valid_d = 1'b0;
        s1_tag_d   = s1_tag_q;
        s1_index_d = s1_index_q;
        upd_ready  = 1'b0;
        req_ready  = 1'b0;
        tag_csb0   = 1'b1;
        tag_web0   = 1'b1;
        tag_addr0  = '0;
        tag_din0   = '0;
        case (state_q)
            RST: begin
                state_d = INIT;
                sweep_d = '0;
            end
            INIT: begin
                tag_csb0  = 1'b0;
                tag_web0  = 1'b0;
                tag_addr0 = sweep_q;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                upd_ready = !inv_all;
                req_ready = !inv_all && !upd_valid;
                // Updates win the single port; a stalled lookup retries next cycle.
                if (inv_all) begin
                    state_d = INIT;
                    sweep_d = '0;
                end else if (upd_valid) begin
                    tag_csb0  = 1'b0;
                    tag_web0  = 1'b0;
                    tag_addr0 = upd_index;
                    tag_din0  = {upd_v, upd_d, upd_tag};
                end else if (req_valid) begin
                    tag_csb0   = 1'b0;
                    tag_addr0  = req_index;
                    s1_valid_d = 1'b1;
                    s1_tag_d   = req_tag;
                    s1_index_d = req_index;
                end
            end
            default: state_d = RST;
        endcase
    end

    // Response fields hold their last value between strobes.
    always_comb begin
        rsp_valid_d = s1_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_dirty_d = rsp_dirty_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_index_d = rsp_index_q;
        if (s1_valid_q) begin
            rsp_hit_d   = tag_dout0[V_BIT] && (tag_dout0[TAG_MSB:0] == s1_tag_q);
            rsp_dirty_d = tag_dout0[D_BIT];
            rsp_tag_d   = tag_dout0[TAG_MSB:0];
            rsp_index_d = s1_index_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST;
            sweep_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_index_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_dirty_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_index_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_index_q  <= s1_index_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_dirty_q <= rsp_dirty_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_index_q <= rsp_index_d;
        end
    end

    assign init_done = (state_q == RUN);
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_dirty = rsp_dirty_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_index = rsp_index_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_tag_ctrl.sv
// ============================================================================
// tb_dcache_tag_ctrl : scoreboard bench for dcache_tag_ctrl with an SRAM model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        upd_valid, upd_ready;
    logic [3:0]  upd_index;
    logic [22:0] upd_tag;
    logic        upd_v, upd_d, inv_all;
    logic        init_done, rsp_valid, rsp_hit, rsp_dirty;
    logic [22:0] rsp_tag;
    logic [3:0]  rsp_index;
    logic        tag_csb0, tag_web0;
    logic [3:0]  tag_addr0;
    logic [24:0] tag_din0;
    logic [24:0] tag_dout0;

    always #5 clk = ~clk;

    dcache_tag_ctrl #(
        .OFFSET_WIDTH(5), .INDEX_WIDTH(4), .TAG_WIDTH(23), .WORD_WIDTH(25)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_tag(upd_tag), .upd_v(upd_v), .upd_d(upd_d),
        .inv_all(inv_all), .init_done(init_done),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty),
        .rsp_tag(rsp_tag), .rsp_index(rsp_index),
        .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
        .tag_din0(tag_din0), .tag_dout0(tag_dout0)
    );

    // Tag SRAM model; 'corrupt' fills it with valid/dirty/tag-0 garbage.
    logic [24:0] sram [16];
    logic        corrupt;
    always @(posedge clk) begin
        if (corrupt) begin
            for (int i = 0; i < 16; i++) sram[i] <= {2'b11, 23'h0};
        end else if (!tag_csb0) begin
            if (!tag_web0) sram[tag_addr0] <= tag_din0;
            else           tag_dout0       <= sram[tag_addr0];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic        hit;
        logic        dirty;
        logic [22:0] tag;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_push, e_pop;
    logic [24:0] ref_mem [16];
    logic [24:0] ref_w;
    int          cyc;
    int          sweep_base;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            sweep_base <= 0;
            for (int i = 0; i < 16; i++) ref_mem[i] <= '0;
        end else begin
            if (cyc > sweep_base && cyc <= sweep_base + 16) begin
                check_val("sweep_csb", 64'(tag_csb0), 64'(0));
                check_val("sweep_web", 64'(tag_web0), 64'(0));
                check_val("sweep_addr", 64'(tag_addr0), 64'(cyc - sweep_base - 1));
                check_val("sweep_din", 64'(tag_din0), 64'(0));
                check_val("sweep_init_low", 64'(init_done), 64'(0));
            end
            if (cyc == sweep_base + 17) check_val("init_high", 64'(init_done), 64'(1));
            if (init_done && inv_all) begin
                sweep_base <= cyc;
                for (int i = 0; i < 16; i++) ref_mem[i] <= '0;
            end
            if (upd_valid && upd_ready) ref_mem[upd_index] <= {upd_v, upd_d, upd_tag};
            if (req_valid && req_ready) begin
                ref_w        = ref_mem[req_addr[8:5]];
                e_push.due   = cyc + 2;
                e_push.hit   = ref_w[24] && (ref_w[22:0] == req_addr[31:9]);
                e_push.dirty = ref_w[23];
                e_push.tag   = ref_w[22:0];
                e_push.idx   = req_addr[8:5];
                sb.push_back(e_push);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_val("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e_pop = sb.pop_front();
                    check_val("rsp_cycle", 64'(cyc), 64'(e_pop.due));
                    check_val("rsp_hit", 64'(rsp_hit), 64'(e_pop.hit));
                    check_val("rsp_dirty", 64'(rsp_dirty), 64'(e_pop.dirty));
                    check_val("rsp_tag", 64'(rsp_tag), 64'(e_pop.tag));
                    check_val("rsp_index", 64'(rsp_index), 64'(e_pop.idx));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check_val("rsp_missing", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive_idle();
        req_valid = 1'b0; req_addr = '0; upd_valid = 1'b0; upd_index = '0;
        upd_tag = '0; upd_v = 1'b0; upd_d = 1'b0; inv_all = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic do_req(input logic [31:0] a);
        @(posedge clk); #1;
        drive_idle();
        req_valid = 1'b1; req_addr = a;
    endtask

    task automatic do_upd(input logic [3:0] i, input logic [22:0] t, input logic v, input logic d);
        @(posedge clk); #1;
        drive_idle();
        upd_valid = 1'b1; upd_index = i; upd_tag = t; upd_v = v; upd_d = d;
    endtask

    task automatic chk_reset();
        check_val("rst_init_done", 64'(init_done), 64'(0));
        check_val("rst_req_ready", 64'(req_ready), 64'(0));
        check_val("rst_upd_ready", 64'(upd_ready), 64'(0));
        check_val("rst_rsp", 64'({rsp_valid, rsp_hit, rsp_dirty, rsp_tag, rsp_index}), 64'(0));
        check_val("rst_csb_web", 64'({tag_csb0, tag_web0}), 64'(3));
        check_val("rst_addr_din", 64'({tag_addr0, tag_din0}), 64'(0));
    endtask

    task automatic wait_init(input string tag, input int exp_cyc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        check_val(tag, 64'(cyc), 64'(exp_cyc));
    endtask

    function automatic logic [31:0] mk_addr(input logic [22:0] t, input logic [3:0] i);
        return {t, i, 5'b0};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int inv_cyc;

    initial begin
        rst_n   = 1'b0;
        corrupt = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        chk_reset();
        corrupt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_cycle", 17);

        // Swept array: address 0 must miss despite the valid garbage.
        do_req(32'h0000_0000);
        idle();

        // Fill then hit on the very next cycle.
        do_upd(4'd3, 23'h12345, 1'b1, 1'b1);
        do_req(32'h0246_8A60);
        idle();
        @(posedge clk); @(negedge clk);
        check_val("fill_valid", 64'(rsp_valid), 64'(1));
        check_val("fill_hit", 64'(rsp_hit), 64'(1));
        check_val("fill_dirty", 64'(rsp_dirty), 64'(1));
        check_val("fill_index", 64'(rsp_index), 64'(3));

        // Back-to-back: hit then miss on the same set.
        do_req(32'h0246_8A60);
        do_req(32'h0246_8C60);
        idle();
        @(negedge clk);
        check_val("b2b_hit", 64'(rsp_hit), 64'(1));
        @(negedge clk);
        check_val("b2b_miss_valid", 64'(rsp_valid), 64'(1));
        check_val("b2b_miss_hit", 64'(rsp_hit), 64'(0));
        check_val("b2b_miss_tag", 64'(rsp_tag), 64'(23'h12345));

        // Update and lookup together: update wins, lookup follows.
        @(posedge clk); #1;
        drive_idle();
        upd_valid = 1'b1; upd_index = 4'd7; upd_tag = 23'h00ABC; upd_v = 1'b1; upd_d = 1'b0;
        req_valid = 1'b1; req_addr = mk_addr(23'h00ABC, 4'd7);
        #1;
        check_val("sim_req_ready", 64'(req_ready), 64'(0));
        check_val("sim_upd_ready", 64'(upd_ready), 64'(1));
        @(posedge clk); #1;
        upd_valid = 1'b0;
        #1;
        check_val("sim_req_ready_next", 64'(req_ready), 64'(1));
        idle();
        @(posedge clk); @(negedge clk);
        check_val("sim_hit", 64'(rsp_hit), 64'(1));
        check_val("sim_dirty", 64'(rsp_dirty), 64'(0));

        // More fills, then inv_all with a lookup in flight.
        do_upd(4'd0, 23'h7FFFFF, 1'b1, 1'b0);
        do_upd(4'd5, 23'h00055, 1'b1, 1'b1);
        do_upd(4'd15, 23'h40000, 1'b1, 1'b0);
        do_req(mk_addr(23'h00055, 4'd5));
        @(posedge clk); #1;
        drive_idle();
        inv_all = 1'b1; req_valid = 1'b1; req_addr = mk_addr(23'h7FFFFF, 4'd0);
        inv_cyc = cyc;
        #1;
        check_val("inv_req_ready", 64'(req_ready), 64'(0));
        check_val("inv_upd_ready", 64'(upd_ready), 64'(0));
        @(posedge clk); #1;
        drive_idle();
        wait_init("inv_init_cycle", inv_cyc + 17);
        do_req(mk_addr(23'h7FFFFF, 4'd0));
        do_req(mk_addr(23'h00055, 4'd5));
        do_req(mk_addr(23'h40000, 4'd15));
        do_req(32'h0246_8A60);
        idle();
        repeat (3) @(negedge clk);

        // Reset in sweep cycle 8, with the SRAM re-corrupted.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cyc == 8) break;
            @(negedge clk);
        end
        check_val("mid_sweep_cycle", 64'(cyc), 64'(8));
        rst_n   = 1'b0;
        corrupt = 1'b1;
        #1;
        chk_reset();
        @(negedge clk);
        @(negedge clk);
        corrupt = 1'b0;
        rst_n   = 1'b1;
        wait_init("reinit_cycle", 17);
        do_req(mk_addr(23'h0, 4'd0));
        do_req(mk_addr(23'h0, 4'd8));
        do_req(mk_addr(23'h0, 4'd15));
        idle();
        repeat (4) @(negedge clk);
        check_val("sb_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
